// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Interlock and flush controller for the in-order core.
//   - Per-register scoreboard of destinations issued past decode and not yet
//     written back; decode is held while any source or the destination of the
//     instruction in decode has a write outstanding, or while the in-flight
//     window is full.
//   - Multi-cycle flush of fetch/decode after an execute redirect.
//   - Saturating stall / flush event counters.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dec_*                      instruction currently in decode
//   wb_valid/wb_rd_used/_addr  instruction retiring this cycle
//   redirect_valid             execute redirected the PC
//   stall, issue               combinational decode control
//   flush                      registered fetch/decode invalidate
//   pending_mask, inflight_cnt registered scoreboard state
//   stall_count, flush_count   saturating performance counters
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dec_valid,
    input  logic [REG_ADDR_W-1:0]      dec_rs1_addr,
    input  logic                       dec_rs1_used,
    input  logic [REG_ADDR_W-1:0]      dec_rs2_addr,
    input  logic                       dec_rs2_used,
    input  logic [REG_ADDR_W-1:0]      dec_rd_addr,
    input  logic                       dec_rd_used,
    input  logic                       wb_valid,
    input  logic                       wb_rd_used,
    input  logic [REG_ADDR_W-1:0]      wb_rd_addr,
    input  logic                       redirect_valid,
    output logic                       stall,
    output logic                       flush,
    output logic                       issue,
    output logic [(1<<REG_ADDR_W)-1:0] pending_mask,
    output logic [3:0]                 inflight_cnt,
    output logic [CNT_W-1:0]           stall_count,
    output logic [CNT_W-1:0]           flush_count
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic {ST_IDLE, ST_FLUSHING} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            flush_cnt_reg, flush_cnt_next;
    logic [NUM_REGS-1:0]   pending_mask_reg, pending_mask_next;
    logic [3:0]            inflight_cnt_reg, inflight_cnt_next;
    logic [CNT_W-1:0]      stall_count_reg, stall_count_next;
    logic [CNT_W-1:0]      flush_count_reg, flush_count_next;

    logic raw1, raw2, waw, full, wb_retire;

    // Hazards look only at registered state: a writeback this cycle does not
    // release a waiting instruction until the next cycle, since the register
    // file has no write-to-read bypass.
    assign raw1 = dec_rs1_used && (dec_rs1_addr != '0) && pending_mask_reg[dec_rs1_addr];
    assign raw2 = dec_rs2_used && (dec_rs2_addr != '0) && pending_mask_reg[dec_rs2_addr];
    assign waw  = dec_rd_used  && (dec_rd_addr  != '0) && pending_mask_reg[dec_rd_addr];
    assign full = (inflight_cnt_reg == 4'(MAX_INFLIGHT));

    assign stall = dec_valid && !flush && (raw1 || raw2 || waw || full);
    assign issue = dec_valid && !flush && !stall;

    // Scoreboard: one bit per register. Set takes priority over clear so a
    // retire and a re-issue of the same register leave it pending.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending_mask_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit, clr_bit;
                assign set_bit = issue && dec_rd_used && (dec_rd_addr == REG_ADDR_W'(gi));
                assign clr_bit = wb_valid && wb_rd_used && (wb_rd_addr == REG_ADDR_W'(gi));
                assign pending_mask_next[gi] = set_bit || (pending_mask_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    // A writeback with nothing in flight is a protocol error and is ignored.
    assign wb_retire = wb_valid && (inflight_cnt_reg != 4'd0);

    always_comb begin
        inflight_cnt_next = inflight_cnt_reg;
        if (issue && !wb_retire)
            inflight_cnt_next = inflight_cnt_reg + 4'd1;
        else if (!issue && wb_retire)
            inflight_cnt_next = inflight_cnt_reg - 4'd1;
    end

    // Flush FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            flush_cnt_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Flush FSM: next state. A redirect always (re)loads the full window.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        if (redirect_valid) begin
            state_next     = ST_FLUSHING;
            flush_cnt_next = 3'(FLUSH_CYCLES);
        end else if (state_reg == ST_FLUSHING) begin
            flush_cnt_next = flush_cnt_reg - 3'd1;
            if (flush_cnt_reg == 3'd1)
                state_next = ST_IDLE;
        end
    end

    // Flush FSM: output
    always_comb begin
        flush = 1'b0;
        if (state_reg == ST_FLUSHING)
            flush = 1'b1;
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall && (stall_count_reg != '1))
            stall_count_next = stall_count_reg + CNT_W'(1);
        flush_count_next = flush_count_reg;
        if (redirect_valid && (flush_count_reg != '1))
            flush_count_next = flush_count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_mask_reg <= '0;
            inflight_cnt_reg <= 4'd0;
            stall_count_reg  <= '0;
            flush_count_reg  <= '0;
        end else begin
            pending_mask_reg <= pending_mask_next;
            inflight_cnt_reg <= inflight_cnt_next;
            stall_count_reg  <= stall_count_next;
            flush_count_reg  <= flush_count_next;
        end
    end

`ifdef SIMULATE
    always @(posedge clk) begin
        if (!reset && wb_valid && (inflight_cnt_reg == 4'd0))
            $display("pipe_hazard_ctrl: protocol error, writeback with nothing in flight ignored");
    end
`endif

    assign pending_mask = pending_mask_reg;
    assign inflight_cnt = inflight_cnt_reg;
    assign stall_count  = stall_count_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of per-cycle vectors, each pushed to
// an expectation queue when driven and compared when sampled mid-cycle.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1_addr;
    logic        dec_rs1_used;
    logic [4:0]  dec_rs2_addr;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd_addr;
    logic        dec_rd_used;
    logic        wb_valid;
    logic        wb_rd_used;
    logic [4:0]  wb_rd_addr;
    logic        redirect_valid;
    logic        stall;
    logic        flush;
    logic        issue;
    logic [31:0] pending_mask;
    logic [3:0]  inflight_cnt;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    pipe_hazard_ctrl #(
        .REG_ADDR_W(5), .MAX_INFLIGHT(4), .FLUSH_CYCLES(2), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
        .dec_rd_addr(dec_rd_addr), .dec_rd_used(dec_rd_used),
        .wb_valid(wb_valid), .wb_rd_used(wb_rd_used), .wb_rd_addr(wb_rd_addr),
        .redirect_valid(redirect_valid),
        .stall(stall), .flush(flush), .issue(issue),
        .pending_mask(pending_mask), .inflight_cnt(inflight_cnt),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        rst;
        logic        dv;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic [4:0]  rd;
        logic        rdu;
        logic        wbv;
        logic [4:0]  wba;
        logic        rdr;
        logic        e_st;
        logic        e_is;
        logic        e_fl;
        logic [31:0] e_pm;
        logic [3:0]  e_inf;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(input logic dv, input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u,
                               input logic [4:0] rd, input logic rdu,
                               input logic wbv, input logic [4:0] wba, input logic rdr,
                               input logic est, input logic eis, input logic efl,
                               input logic [31:0] epm, input logic [3:0] einf,
                               input logic [31:0] esc, input logic [31:0] efc);
        vec_t r;
        r.idx = 0; r.rst = 1'b0; r.dv = dv;
        r.rs1 = rs1; r.rs1u = rs1u; r.rs2 = rs2; r.rs2u = rs2u;
        r.rd = rd; r.rdu = rdu; r.wbv = wbv; r.wba = wba; r.rdr = rdr;
        r.e_st = est; r.e_is = eis; r.e_fl = efl; r.e_pm = epm;
        r.e_inf = einf; r.e_sc = esc; r.e_fc = efc;
        return r;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL vec %0d %s: got %0h expected %0h", idx, name, act, expv);
        end
    endtask

    // Compare in the middle of each cycle, after inputs have settled.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            int   bad_before;
            e = exp_q.pop_front();
            bad_before = bad;
            chk(e.idx, "stall",        32'(stall),        32'(e.e_st));
            chk(e.idx, "issue",        32'(issue),        32'(e.e_is));
            chk(e.idx, "flush",        32'(flush),        32'(e.e_fl));
            chk(e.idx, "pending_mask", pending_mask,      e.e_pm);
            chk(e.idx, "inflight_cnt", 32'(inflight_cnt), 32'(e.e_inf));
            chk(e.idx, "stall_count",  stall_count,       e.e_sc);
            chk(e.idx, "flush_count",  flush_count,       e.e_fc);
            $display("vec %0d: rst=%0b dv=%0b stall=%0b issue=%0b flush=%0b pm=%08h inf=%0d sc=%0d fc=%0d errors=%0d",
                     e.idx, e.rst, e.dv, stall, issue, flush, pending_mask, inflight_cnt,
                     stall_count, flush_count, bad - bad_before);
        end
    end

    task automatic apply(input vec_t t, input int idx);
        vec_t q;
        @(posedge clk);
        #1;
        reset          = t.rst;
        dec_valid      = t.dv;
        dec_rs1_addr   = t.rs1;
        dec_rs1_used   = t.rs1u;
        dec_rs2_addr   = t.rs2;
        dec_rs2_used   = t.rs2u;
        dec_rd_addr    = t.rd;
        dec_rd_used    = t.rdu;
        wb_valid       = t.wbv;
        wb_rd_used     = t.wbv;
        wb_rd_addr     = t.wba;
        redirect_valid = t.rdr;
        q = t;
        q.idx = idx;
        exp_q.push_back(q);
    endtask

    initial begin
        vec_t h;
        reset = 1'b1; dec_valid = 1'b0; dec_rs1_addr = '0; dec_rs1_used = 1'b0;
        dec_rs2_addr = '0; dec_rs2_used = 1'b0; dec_rd_addr = '0; dec_rd_used = 1'b0;
        wb_valid = 1'b0; wb_rd_used = 1'b0; wb_rd_addr = '0; redirect_valid = 1'b0;
        repeat (2) @(posedge clk);

        //            dv rs1    u  rs2   u  rd     u  wbv wba  rdr  st is fl  pm         inf  sc  fc
        // reset state, first issue
        vecs.push_back(v(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 32'h0,     0, 0, 0));
        vecs.push_back(v(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 5'd0, 0, 0, 1, 0, 32'h0,     0, 0, 0));
        vecs.push_back(v(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 1, 0, 32'h10,    1, 0, 0));
        // RAW on rs2 = 5 until its writeback, issue one cycle later
        vecs.push_back(v(1, 5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 5'd0, 0, 1, 0, 0, 32'h30,    2, 0, 0));
        vecs.push_back(v(1, 5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 5'd0, 0, 1, 0, 0, 32'h30,    2, 1, 0));
        vecs.push_back(v(1, 5'd0, 0, 5'd5, 1, 5'd6, 1, 1, 5'd5, 0, 1, 0, 0, 32'h30,    2, 2, 0));
        vecs.push_back(v(1, 5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 5'd0, 0, 0, 1, 0, 32'h10,    1, 3, 0));
        // RAW on rs1
        vecs.push_back(v(1, 5'd4, 1, 5'd0, 0, 5'd12,0, 0, 5'd0, 0, 1, 0, 0, 32'h50,    2, 3, 0));
        // x0 as source and destination
        vecs.push_back(v(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0, 0, 1, 0, 32'h50,    2, 4, 0));
        // simultaneous set and clear of r7: set wins, count unchanged
        vecs.push_back(v(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 5'd7, 0, 0, 1, 0, 32'h50,    3, 4, 0));
        // capacity
        vecs.push_back(v(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 5'd0, 0, 0, 1, 0, 32'hD0,    3, 4, 0));
        vecs.push_back(v(1, 5'd10,1, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0, 1, 0, 0, 32'h1D0,   4, 4, 0));
        vecs.push_back(v(1, 5'd10,1, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0, 1, 0, 0, 32'h1D0,   4, 5, 0));
        vecs.push_back(v(1, 5'd10,1, 5'd0, 0, 5'd9, 1, 1, 5'd4, 0, 1, 0, 0, 32'h1D0,   4, 6, 0));
        vecs.push_back(v(1, 5'd10,1, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0, 0, 1, 0, 32'h1C0,   3, 7, 0));
        vecs.push_back(v(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 32'h3C0,   4, 7, 0));
        // redirect, second redirect one cycle later extends flush
        vecs.push_back(v(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd6, 1, 0, 0, 0, 32'h3C0,   4, 7, 0));
        vecs.push_back(v(1, 5'd7, 1, 5'd0, 0, 5'd11,1, 0, 5'd0, 1, 0, 0, 1, 32'h380,   3, 7, 1));
        vecs.push_back(v(1, 5'd7, 1, 5'd0, 0, 5'd11,1, 0, 5'd0, 0, 0, 0, 1, 32'h380,   3, 7, 2));
        vecs.push_back(v(1, 5'd7, 1, 5'd0, 0, 5'd11,1, 0, 5'd0, 0, 0, 0, 1, 32'h380,   3, 7, 2));
        vecs.push_back(v(1, 5'd7, 0, 5'd0, 0, 5'd11,1, 0, 5'd0, 0, 0, 1, 0, 32'h380,   3, 7, 2));
        vecs.push_back(v(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 1, 0, 0, 0, 32'hB80,   4, 7, 2));

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-flight: three writers pending and flush active, then
        // reset arrives together with other activity.
        h = v(1, 5'd8, 1, 5'd0, 0, 5'd13, 1, 0, 5'd0, 0, 0, 0, 1, 32'hB00, 3, 7, 3);
        apply(h, 100);
        h = v(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 1, 5'd8, 1, 0, 0, 1, 32'hB00, 3, 7, 3);
        h.rst = 1'b1;
        apply(h, 101);
        h = v(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        apply(h, 102);
        apply(h, 103);
        // after reset, an instruction on an empty scoreboard issues at once
        h = v(1, 5'd8, 1, 5'd9, 1, 5'd11, 1, 0, 5'd0, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        apply(h, 104);

        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
